wb_arbiter_rr: RTL and testbench

- Parametrised N-master to 1-slave Wishbone B3 arbiter for the system interconnect.
- Sits between per-master wb_mux slave ports and a shared slave, such as a memory dbus port or a peripheral data-resize stage.
- Generalises the fixed two-master arbiter:
  - configurable master count and bus widths;
  - registered round-robin fairness;
  - a guaranteed bus-idle cycle between owners;
  - optional watchdog that aborts hung slave accesses with err.

---
 rtl/wb_arbiter_rr.sv | 208 ++++++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master to 1-slave Wishbone B3 arbiter with registered
// round-robin fairness and a forced bus-idle cycle between owners.
// Optional watchdog, enabled by defining WB_ARB_TIMEOUT_EN, aborts a slave
// access that stalls for TIMEOUT cycles and answers the owner with err.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [NUM_MASTERS-1:0]      wbm_gnt_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef WB_ARB_TIMEOUT_EN
    ST_ABORT = 2'd2,
`endif
    ST_GRANT = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   last_idx_q, last_idx_d;
  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic            own_cyc_s, own_stb_s, own_we_s;
  logic            in_grant_s, in_abort_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0]     stall_q, stall_d;
  logic            stalled_s;
  assign in_abort_s = (state_q == ST_ABORT);
  assign stalled_s  = wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
`else
  // The watchdog limit has no meaning without the watchdog.
  logic unused_timeout_s;
  assign unused_timeout_s = ^(16'(TIMEOUT));
  assign in_abort_s       = 1'b0;
`endif

  assign in_grant_s = (state_q == ST_GRANT);
  assign wbs_cyc_o  = own_cyc_s & in_grant_s;
  assign wbs_stb_o  = own_stb_s & in_grant_s;
  assign wbs_we_o   = own_we_s  & in_grant_s;
  assign wbm_dat_o  = {NUM_MASTERS{wbs_dat_i}};

  // Round-robin pick: lowest requester above last owner, else wrap to lowest.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found_s && wbm_cyc_i[i] && (IW'(i) > last_idx_q)) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'(i);
      end else begin
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found_s && wbm_cyc_i[i] && (IW'(i) <= last_idx_q)) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'(i);
      end else begin
      end
    end
  end

  // Forward the master at gnt_idx onto the slave side.
  always_comb begin
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    own_we_s  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (IW'(i) == gnt_idx_q) begin
        own_cyc_s = wbm_cyc_i[i];
        own_stb_s = wbm_stb_i[i];
        own_we_s  = wbm_we_i[i];
        wbs_adr_o = wbm_adr_i[i*AW +: AW];
        wbs_dat_o = wbm_dat_i[i*DW +: DW];
        wbs_sel_o = wbm_sel_i[i*SW +: SW];
        wbs_cti_o = wbm_cti_i[i*3 +: 3];
        wbs_bte_o = wbm_bte_i[i*2 +: 2];
      end else begin
      end
    end
  end

  // Route responses and the grant vector to the owner only.
  always_comb begin
    wbm_gnt_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((state_q != ST_IDLE) && (IW'(i) == gnt_idx_q)) begin
        wbm_gnt_o[i] = 1'b1;
        wbm_ack_o[i] = in_grant_s & wbs_ack_i;
        wbm_err_o[i] = (in_grant_s & wbs_err_i) | in_abort_s;
        wbm_rty_o[i] = in_grant_s & wbs_rty_i;
      end else begin
      end
    end
  end

  // Next-state: grant on request, hold for the whole cyc, release via IDLE.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
`ifdef WB_ARB_TIMEOUT_EN
    stall_d    = 16'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d   = ST_GRANT;
          gnt_idx_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!own_cyc_s) begin
          state_d    = ST_IDLE;
          last_idx_d = gnt_idx_q;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (stalled_s && (stall_q == TO_LIM)) begin
          state_d = ST_ABORT;
        end else if (stalled_s) begin
          stall_d = stall_q + 16'd1;
        end
`endif
        else begin
          state_d = ST_GRANT;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (own_cyc_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d    = ST_IDLE;
          last_idx_d = gnt_idx_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset leaves the last owner at the top so master 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_idx_q <= IW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      stall_q    <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
`ifdef WB_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: random masters and a random-latency slave,
// every cycle compared against a transaction-level reference model.
module tb_wb_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   wbm_adr_i;
  logic [N*DW-1:0]   wbm_dat_i;
  logic [N*SW-1:0]   wbm_sel_i;
  logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]    wbm_cti_i;
  logic [N*2-1:0]    wbm_bte_i;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_gnt_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [SW-1:0]     wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  always #5 clk = ~clk;

  wb_arbiter_rr #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o), .wbm_gnt_o(wbm_gnt_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus and how long its strobe has stalled.
  int m_busy;       // 1 while some master holds the bus (grant or abort cycle)
  int m_abort;      // 1 during the single abort cycle
  int m_owner;      // index of the current / most recent owner
  int m_prev;       // owner that most recently finished
  int m_waited;     // consecutive stalled strobe cycles of the owner

  logic [N-1:0] resp_seen, gnt_seen;
  int slave_wait;
  int waits [8] = '{0, 0, 0, 1, 2, 7, 8, 20};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge: compare, then advance the model past the next rising edge.
  task automatic cycle_check();
    logic [N-1:0] eg, ea, ee, er;
    logic         owner_cyc, owner_stb, s_cyc, s_stb, s_we, resp;
    int           g;
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0; m_abort = 0; m_owner = 0; m_prev = N - 1; m_waited = 0;
    end
    g = m_owner;
    owner_cyc = wbm_cyc_i[g];
    owner_stb = wbm_stb_i[g];
    s_cyc = (m_busy == 1) && (m_abort == 0) && owner_cyc;
    s_stb = (m_busy == 1) && (m_abort == 0) && owner_stb;
    s_we  = (m_busy == 1) && (m_abort == 0) && wbm_we_i[g];
    resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    eg = '0; ea = '0; ee = '0; er = '0;
    if (m_busy == 1) begin
      eg[g] = 1'b1;
      ea[g] = (m_abort == 0) && wbs_ack_i;
      ee[g] = (m_abort == 1) || wbs_err_i;
      er[g] = (m_abort == 0) && wbs_rty_i;
    end
    check_eq("gnt", wbm_gnt_o, eg);
    check_eq("ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, {s_cyc, s_stb, s_we});
    check_eq("ack", wbm_ack_o, ea);
    check_eq("err", wbm_err_o, ee);
    check_eq("rty", wbm_rty_o, er);
    check_eq("fields", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o},
             {wbm_adr_i[g*AW +: AW], wbm_dat_i[g*DW +: DW], wbm_sel_i[g*SW +: SW],
              wbm_cti_i[g*3 +: 3], wbm_bte_i[g*2 +: 2]});
    check_eq("rdata", wbm_dat_o, {N{wbs_dat_i}});
    resp_seen = ea | ee | er;
    gnt_seen  = eg;
    if (rst_n) begin
      if (m_busy == 0) begin
        for (int k = 1; k <= N; k++) begin
          if ((m_busy == 0) && wbm_cyc_i[(m_prev + k) % N]) begin
            m_busy = 1; m_owner = (m_prev + k) % N; m_waited = 0;
          end
        end
      end else if (m_abort == 1) begin
        m_abort = 0; m_waited = 0;
        if (!owner_cyc) begin m_busy = 0; m_prev = g; end
      end else if (!owner_cyc) begin
        m_busy = 0; m_prev = g; m_waited = 0;
      end else if (s_stb && !resp) begin
        m_waited = m_waited + 1;
        if (TO_EN && (m_waited == TO)) begin m_abort = 1; m_waited = 0; end
      end else begin
        m_waited = 0;
      end
    end
  endtask

  task automatic new_beat(input int i);
    wbm_stb_i[i] = 1'b1;
    wbm_we_i[i]  = 1'($urandom_range(0, 1));
    wbm_adr_i[i*AW +: AW] = $urandom();
    wbm_dat_i[i*DW +: DW] = $urandom();
    wbm_sel_i[i*SW +: SW] = 4'($urandom());
    wbm_cti_i[i*3 +: 3]   = 3'($urandom());
    wbm_bte_i[i*2 +: 2]   = 2'($urandom());
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      if (wbm_cyc_i[i]) begin
        if (resp_seen[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            wbm_cyc_i[i] = 1'b0; wbm_stb_i[i] = 1'b0;
          end else begin
            new_beat(i);
          end
        end else if (!gnt_seen[i] && ($urandom_range(0, 31) == 0)) begin
          wbm_cyc_i[i] = 1'b0; wbm_stb_i[i] = 1'b0;
        end else if (gnt_seen[i]) begin
          wbm_stb_i[i] = ($urandom_range(0, 7) != 0);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        wbm_cyc_i[i] = 1'b1;
        new_beat(i);
      end
    end
  endtask

  task automatic drive_slave();
    int r;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    wbs_dat_i = ($urandom_range(0, 3) == 0) ? 32'hDEADBEEF : $urandom();
    if (wbs_stb_o) begin
      if (slave_wait == 0) begin
        r = $urandom_range(0, 9);
        wbs_ack_i = (r < 8);
        wbs_err_i = (r == 8);
        wbs_rty_i = (r == 9);
        slave_wait = waits[$urandom_range(0, 7)];
      end else begin
        slave_wait--;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cycle_check();
      @(posedge clk);
      #1;
      drive_masters();
      #1;
      drive_slave();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wbm_cyc_i = '1; wbm_stb_i = '1; wbm_we_i = '0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    for (int i = 0; i < N; i++) wbm_adr_i[i*AW +: AW] = 32'h1000 * (i + 1);
    wbs_dat_i = 32'h0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    slave_wait = 0;
    resp_seen = '0; gnt_seen = '0;
    m_busy = 0; m_abort = 0; m_owner = 0; m_prev = N - 1; m_waited = 0;

    // Held in reset with every master requesting: nothing may be granted.
    for (int c = 0; c < 3; c++) begin
      cycle_check();
      check_eq("rst_cyc", wbs_cyc_o, 1'b0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    cycle_check();
    @(posedge clk);
    #1;
    check_eq("rst_first_gnt", wbm_gnt_o, 4'b0001);
    drive_masters();
    #1;
    drive_slave();

    run_cycles(3000);

    // Hung slave: the owner stalls far beyond the watchdog limit.
    slave_wait = 1000;
    run_cycles(1300);

    run_cycles(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
